// File: rtl/interfaz_usuario_atm.sv
// ATM panel front end: keypad and card sensor to controller protocol.
// Sequences PIN entry, transaction type and amount, then awaits result.
module interfaz_usuario_atm #(
  parameter int PIN_DIGITOS = 4,
  parameter int T_VERIF     = 4,
  parameter int MAX_DIG     = 9,
  parameter int T_RESP      = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TARJETA_IN,
  input  logic [3:0]  TECLA,
  input  logic        TECLA_VALIDA,
  input  logic        BALANCE_ACTUALIZADO,
  input  logic        ENTREGAR_DINERO,
  input  logic        FONDOS_INSUFICIENTES,
  input  logic        PIN_INCORRECTO,
  input  logic        ADVERTENCIA,
  input  logic        BLOQUEO_CTRL,
  output logic        TARJETA_RECIBIDA,
  output logic        TIPO_TRANS,
  output logic [3:0]  DIGITO,
  output logic        DIGITO_STB,
  output logic [31:0] MONTO,
  output logic        MONTO_STB,
  output logic        AVISO_PIN,
  output logic        TIMEOUT
);

  localparam logic [2:0] ST_ESPERA = 3'd0;
  localparam logic [2:0] ST_PIN    = 3'd1;
  localparam logic [2:0] ST_VERIF  = 3'd2;
  localparam logic [2:0] ST_SEL    = 3'd3;
  localparam logic [2:0] ST_CAPT   = 3'd4;
  localparam logic [2:0] ST_RES    = 3'd5;
  localparam logic [2:0] ST_FIN    = 3'd6;
  localparam logic [2:0] ST_BLOQ   = 3'd7;

  localparam logic [3:0] K_A = 4'hA;
  localparam logic [3:0] K_B = 4'hB;
  localparam logic [3:0] K_C = 4'hC;
  localparam logic [3:0] K_D = 4'hD;

  localparam int CMAX = (MAX_DIG > PIN_DIGITOS) ? MAX_DIG : PIN_DIGITOS;
  localparam int TMAX = (T_RESP > T_VERIF) ? T_RESP : T_VERIF;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TMAX + 1);

  logic [2:0]    st_q, st_d;
  logic          tv_q;
  logic          evt_q;
  logic [3:0]    key_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [31:0]   acc_q, acc_d;
  logic          tarj_q, tarj_d;
  logic          tipo_q, tipo_d;
  logic [3:0]    dig_q, dig_d;
  logic          dstb_q, dstb_d;
  logic [31:0]   monto_q, monto_d;
  logic          mstb_q, mstb_d;
  logic          aviso_q, aviso_d;
  logic          tout_q, tout_d;

  logic go_abort;
  logic go_fin;
  logic is_dig;
  logic result;

  assign is_dig = (key_q <= 4'd9);
  assign result = BALANCE_ACTUALIZADO | ENTREGAR_DINERO
                | FONDOS_INSUFICIENTES;

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    acc_d    = acc_q;
    tarj_d   = tarj_q;
    tipo_d   = tipo_q;
    dig_d    = dig_q;
    dstb_d   = 1'b0;
    monto_d  = monto_q;
    mstb_d   = 1'b0;
    aviso_d  = aviso_q;
    tout_d   = 1'b0;
    go_abort = 1'b0;
    go_fin   = 1'b0;

    unique case (st_q)
      ST_ESPERA: begin
        if (TARJETA_IN) begin
          tarj_d = 1'b1;
          cnt_d  = '0;
          st_d   = ST_PIN;
        end
      end
      ST_PIN: begin
        if (!TARJETA_IN) begin
          go_abort = 1'b1;
        end else if (evt_q && is_dig) begin
          dig_d  = key_q;
          dstb_d = 1'b1;
          if (cnt_q == CW'(PIN_DIGITOS - 1)) begin
            cnt_d = '0;
            tmr_d = '0;
            st_d  = ST_VERIF;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_VERIF: begin
        if (!TARJETA_IN) begin
          go_abort = 1'b1;
        end else if (BLOQUEO_CTRL) begin
          tarj_d = 1'b0;
          st_d   = ST_BLOQ;
        end else if (PIN_INCORRECTO) begin
          cnt_d = '0;
          tmr_d = '0;
          st_d  = ST_PIN;
          if (ADVERTENCIA) aviso_d = 1'b1;
        end else if (tmr_q == TW'(T_VERIF - 1)) begin
          tmr_d = '0;
          st_d  = ST_SEL;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_SEL: begin
        if (!TARJETA_IN) begin
          go_abort = 1'b1;
        end else if (evt_q) begin
          unique case (1'b1)
            (key_q == K_A): begin
              tipo_d = 1'b1;
              acc_d  = '0;
              cnt_d  = '0;
              st_d   = ST_CAPT;
            end
            (key_q == K_B): begin
              tipo_d = 1'b0;
              acc_d  = '0;
              cnt_d  = '0;
              st_d   = ST_CAPT;
            end
            default: ;
          endcase
        end
      end
      ST_CAPT: begin
        if (!TARJETA_IN) begin
          go_abort = 1'b1;
        end else if (evt_q) begin
          unique case (1'b1)
            is_dig: begin
              // extra digits are dropped so the value stays in 32 bits
              if (cnt_q < CW'(MAX_DIG)) begin
                acc_d = acc_q * 32'd10 + {28'd0, key_q};
                cnt_d = cnt_q + CW'(1);
              end
            end
            (key_q == K_D): begin
              acc_d = '0;
              cnt_d = '0;
            end
            (key_q == K_C): begin
              if (cnt_q != '0) begin
                monto_d = acc_q;
                mstb_d  = 1'b1;
                tmr_d   = '0;
                st_d    = ST_RES;
              end
            end
            default: ;
          endcase
        end
      end
      ST_RES: begin
        // card removal is deliberately ignored until the result lands
        if (result) begin
          go_fin = 1'b1;
        end else if (tmr_q == TW'(T_RESP - 1)) begin
          tout_d = 1'b1;
          go_fin = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_FIN: begin
        if (!TARJETA_IN) st_d = ST_ESPERA;
      end
      ST_BLOQ: ;
      default: st_d = ST_ESPERA;
    endcase

    if (go_abort) begin
      st_d    = ST_ESPERA;
      tarj_d  = 1'b0;
      aviso_d = 1'b0;
      cnt_d   = '0;
      tmr_d   = '0;
      acc_d   = '0;
    end
    if (go_fin) begin
      st_d    = ST_FIN;
      tarj_d  = 1'b0;
      aviso_d = 1'b0;
      monto_d = '0;
      acc_d   = '0;
      cnt_d   = '0;
      tmr_d   = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      st_q    <= ST_ESPERA;
      tv_q    <= 1'b0;
      evt_q   <= 1'b0;
      key_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      acc_q   <= '0;
      tarj_q  <= 1'b0;
      tipo_q  <= 1'b0;
      dig_q   <= '0;
      dstb_q  <= 1'b0;
      monto_q <= '0;
      mstb_q  <= 1'b0;
      aviso_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      tv_q    <= TECLA_VALIDA;
      evt_q   <= TECLA_VALIDA & ~tv_q;
      if (TECLA_VALIDA && !tv_q) key_q <= TECLA;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      acc_q   <= acc_d;
      tarj_q  <= tarj_d;
      tipo_q  <= tipo_d;
      dig_q   <= dig_d;
      dstb_q  <= dstb_d;
      monto_q <= monto_d;
      mstb_q  <= mstb_d;
      aviso_q <= aviso_d;
      tout_q  <= tout_d;
    end
  end

  assign TARJETA_RECIBIDA = tarj_q;
  assign TIPO_TRANS       = tipo_q;
  assign DIGITO           = dig_q;
  assign DIGITO_STB       = dstb_q;
  assign MONTO            = monto_q;
  assign MONTO_STB        = mstb_q;
  assign AVISO_PIN        = aviso_q;
  assign TIMEOUT          = tout_q;

endmodule

// File: tb/tb_interfaz_usuario_atm.sv
// Bench for interfaz_usuario_atm: scripted and random sessions,
// strobes checked by a scoreboard against a keypad-level model.
module tb_interfaz_usuario_atm;

  localparam int NPIN = 4;
  localparam int NMAX = 9;

  localparam logic [1:0] KD = 2'd0;
  localparam logic [1:0] KM = 2'd1;
  localparam logic [1:0] KT = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tarj_in;
  logic [3:0]  tecla;
  logic        tv;
  logic        bal, ent, fon, pinc, adv, bloq;
  logic        tr, tipo, dstb, mstb, aviso, tout;
  logic [3:0]  dig;
  logic [31:0] monto;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] kq[$];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  interfaz_usuario_atm dut (
    .CLK                 (clk),
    .RESET               (rst_n),
    .TARJETA_IN          (tarj_in),
    .TECLA               (tecla),
    .TECLA_VALIDA        (tv),
    .BALANCE_ACTUALIZADO (bal),
    .ENTREGAR_DINERO     (ent),
    .FONDOS_INSUFICIENTES(fon),
    .PIN_INCORRECTO      (pinc),
    .ADVERTENCIA         (adv),
    .BLOQUEO_CTRL        (bloq),
    .TARJETA_RECIBIDA    (tr),
    .TIPO_TRANS          (tipo),
    .DIGITO              (dig),
    .DIGITO_STB          (dstb),
    .MONTO               (monto),
    .MONTO_STB           (mstb),
    .AVISO_PIN           (aviso),
    .TIMEOUT             (tout)
  );

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, input logic [1:0] kind,
                         input logic [31:0] val);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected output value %0d, nothing expected",
               name, val);
    end else begin
      e = sb.pop_front();
      chk({name, " kind"}, kind, e.kind);
      chk({name, " value"}, val, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (dstb || mstb) chk("strobe exclusive", dstb & mstb, 0);
      if (dstb) pop_chk("DIGITO_STB", KD, {28'd0, dig});
      if (mstb) pop_chk("MONTO_STB", KM, monto);
      if (tout) pop_chk("TIMEOUT", KT, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    tecla = k;
    tv    = 1'b1;
    repeat (hold) step();
    tv = 1'b0;
    step();
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [31:0] v);
    exp_t e;
    e.kind = kind;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic card_in();
    tarj_in = 1'b1;
    idle(2);
  endtask

  task automatic enter_pin(input int first_hold);
    logic [3:0] d;
    int         h;
    for (int i = 0; i < NPIN; i++) begin
      if ($urandom_range(0, 2) == 0)
        press(4'($urandom_range(10, 15)), $urandom_range(1, 3));
      d = 4'($urandom_range(0, 9));
      expect_ev(KD, {28'd0, d});
      if (i == 0) h = first_hold;
      else if (i == NPIN - 1) h = $urandom_range(1, 2);
      else h = $urandom_range(1, 4);
      press(d, h);
    end
  endtask

  task automatic to_capture(input logic is_dep);
    card_in();
    enter_pin($urandom_range(1, 4));
    idle(8);
    if ($urandom_range(0, 1) == 1)
      press(4'($urandom_range(0, 9)), 2);
    press(is_dep ? 4'hA : 4'hB, 2);
  endtask

  task automatic keys_from(input logic [63:0] pat, input int n);
    kq.delete();
    for (int i = n - 1; i >= 0; i--) kq.push_back(pat[i*4 +: 4]);
  endtask

  // model: amount is the decimal reading of the digits kept, at most NMAX
  task automatic capture(output longint v, output bit sent);
    int unsigned dq[$];
    logic [3:0]  k;
    sent = 1'b0;
    v    = 0;
    foreach (kq[i]) begin
      k = kq[i];
      if (!sent) begin
        if (k <= 4'd9) begin
          if (dq.size() < NMAX) dq.push_back(int'(k));
        end else if (k == 4'hD) begin
          dq.delete();
        end else if (k == 4'hC && dq.size() > 0) begin
          v = 0;
          foreach (dq[j]) v = v * 10 + longint'(dq[j]);
          expect_ev(KM, v[31:0]);
          sent = 1'b1;
        end
      end
      press(k, $urandom_range(1, 3));
    end
  endtask

  task automatic pulse_result(input int which);
    case (which)
      0: bal = 1'b1;
      1: ent = 1'b1;
      default: fon = 1'b1;
    endcase
    step();
    bal = 1'b0;
    ent = 1'b0;
    fon = 1'b0;
  endtask

  task automatic end_session();
    chk("TARJETA_RECIBIDA at FIN", tr, 0);
    chk("MONTO at FIN", monto, 0);
    tarj_in = 1'b0;
    idle(2);
  endtask

  longint v;
  bit     sent;
  logic   dep;

  initial begin
    rst_n = 1'b0;
    tarj_in = 1'b0;
    tecla = '0;
    tv = 1'b0;
    bal = 1'b0;
    ent = 1'b0;
    fon = 1'b0;
    pinc = 1'b0;
    adv = 1'b0;
    bloq = 1'b0;
    #1;
    chk("reset TARJETA_RECIBIDA", tr, 0);
    chk("reset TIPO_TRANS", tipo, 0);
    chk("reset DIGITO", dig, 0);
    chk("reset strobes", {dstb, mstb, tout}, 0);
    chk("reset MONTO", monto, 0);
    chk("reset AVISO_PIN", aviso, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // keys ignored while waiting for a card
    press(4'd3, 2);
    chk("idle TARJETA_RECIBIDA", tr, 0);

    // PIN, rejected with warning, then blocked
    card_in();
    chk("card in TARJETA_RECIBIDA", tr, 1);
    enter_pin(10);
    pinc = 1'b1;
    adv  = 1'b1;
    step();
    pinc = 1'b0;
    adv  = 1'b0;
    chk("AVISO_PIN after warning", aviso, 1);
    chk("TARJETA_RECIBIDA after reject", tr, 1);
    enter_pin(2);
    bloq = 1'b1;
    step();
    bloq = 1'b0;
    chk("blocked TARJETA_RECIBIDA", tr, 0);
    press(4'd1, 2);
    press(4'hA, 2);
    press(4'd2, 2);
    press(4'hC, 2);
    pinc = 1'b1;
    tarj_in = 1'b0;
    idle(2);
    pinc = 1'b0;
    tarj_in = 1'b1;
    idle(3);
    chk("still blocked", tr, 0);
    tarj_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset clears AVISO_PIN", aviso, 0);
    idle(1);
    rst_n = 1'b1;
    idle(2);

    // withdrawal of 500, card pulled while waiting
    to_capture(1'b0);
    keys_from(64'h500C, 4);
    capture(v, sent);
    chk("withdraw TIPO_TRANS", tipo, 0);
    chk("withdraw MONTO", monto, 500);
    tarj_in = 1'b0;
    idle(3);
    chk("removal ignored in wait", tr, 1);
    pulse_result(1);
    end_session();

    // deposit, overflowing digits clamp at nine
    to_capture(1'b1);
    chk("deposit TIPO_TRANS", tipo, 1);
    keys_from(64'h99999999999C, 12);
    capture(v, sent);
    chk("nine nines MONTO", monto, 999999999);
    chk("nine nines model", monto, v);
    pulse_result(0);
    end_session();

    // enter with nothing, then clear in mid entry
    to_capture(1'b0);
    press(4'hC, 2);
    chk("empty enter keeps session", tr, 1);
    keys_from(64'h12D7C, 5);
    capture(v, sent);
    chk("clear then 7 MONTO", monto, 7);
    pulse_result(2);
    end_session();

    // card pulled during PIN
    card_in();
    expect_ev(KD, 32'd4);
    press(4'd4, 2);
    expect_ev(KD, 32'd8);
    press(4'd8, 2);
    tarj_in = 1'b0;
    step();
    chk("abort in PIN", tr, 0);
    press(4'd5, 2);
    press(4'd6, 2);

    // card pulled during capture
    to_capture(1'b1);
    press(4'd3, 2);
    tarj_in = 1'b0;
    step();
    chk("abort in CAPTURA", tr, 0);
    press(4'hC, 2);

    // no result -> timeout
    to_capture(1'b1);
    keys_from(64'h42C, 3);
    capture(v, sent);
    chk("timeout MONTO", monto, 42);
    expect_ev(KT, 32'd0);
    idle(70);
    end_session();

    // random sessions
    for (int s = 0; s < 8; s++) begin
      dep = 1'($urandom_range(0, 1));
      to_capture(dep);
      kq.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++)
        kq.push_back(4'($urandom_range(0, 15)));
      kq.push_back(4'($urandom_range(0, 9)));
      kq.push_back(4'hC);
      capture(v, sent);
      chk("random TIPO_TRANS", tipo, dep);
      chk("random MONTO", monto, v);
      if ($urandom_range(0, 3) == 0) begin
        expect_ev(KT, 32'd0);
        idle(70);
      end else begin
        pulse_result($urandom_range(0, 2));
      end
      end_session();
    end

    // reset in the middle of capture
    to_capture(1'b1);
    press(4'd3, 2);
    press(4'd4, 2);
    rst_n = 1'b0;
    #1;
    chk("async reset TARJETA_RECIBIDA", tr, 0);
    chk("async reset TIPO_TRANS", tipo, 0);
    chk("async reset DIGITO", dig, 0);
    chk("async reset MONTO", monto, 0);
    chk("async reset strobes", {dstb, mstb, tout, aviso}, 0);
    idle(2);

    chk("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interfaz_usuario_atm.md
Name: interfaz_usuario_atm

Overview:
User-side front end for the ATM transaction controller. Turns raw keypad events and the card sensor into the controller's input protocol: TARJETA_RECIBIDA, DIGITO/DIGITO_STB, TIPO_TRANS, and MONTO/MONTO_STB. It also consumes the controller's result outputs so that it can sequence the session and return to idle. It sits between the panel hardware and the controller, on the same clock.

Parameters:
PIN_DIGITOS, 4, number of PIN digits forwarded before the PIN-verification wait
T_VERIF, 4, cycles to wait for PIN_INCORRECTO after the last PIN digit before PIN is treated as accepted
MAX_DIG, 9, maximum amount digits accumulated (9 keeps the value ≤ 999999999, which fits 32 bits)
T_RESP, 64, cycles to wait for a controller result after MONTO_STB before timeout

Ports:
CLK in 1 system clock, all logic on rising edge
RESET in 1 asynchronous reset, active-low
TARJETA_IN in 1 card sensor level, 1 = card present
TECLA in 4 key code: 0-9 digit, A deposit, B withdrawal, C enter, D clear, E/F ignored
TECLA_VALIDA in 1 level, high while a key is held
BALANCE_ACTUALIZADO in 1 controller: deposit done
ENTREGAR_DINERO in 1 controller: withdrawal done
FONDOS_INSUFICIENTES in 1 controller: withdrawal rejected
PIN_INCORRECTO in 1 controller: PIN rejected
ADVERTENCIA in 1 controller: last PIN attempt warning
BLOQUEO_CTRL in 1 controller: card blocked
TARJETA_RECIBIDA out 1 to controller, card session active
TIPO_TRANS out 1 to controller, 1 = deposit, 0 = withdrawal
DIGITO out 4 to controller, PIN digit
DIGITO_STB out 1 to controller, 1-cycle strobe qualifying DIGITO
MONTO out 32 to controller, binary amount
MONTO_STB out 1 to controller, 1-cycle strobe qualifying MONTO
AVISO_PIN out 1 registered copy of ADVERTENCIA, cleared at session end
TIMEOUT out 1 1-cycle pulse on result timeout

Behaviour:
- Reset (RESET=0, async): state ESPERA_TARJETA. All outputs 0. Accumulator, digit count and timers are 0.
- Key event: TECLA_VALIDA sampled 1 and previous sample 0. TECLA is captured at that edge. A held key produces exactly one event. Outputs react on the next edge (1-cycle latency).
- ESPERA_TARJETA: when TARJETA_IN=1, set TARJETA_RECIBIDA=1 and go to PIN. Keys are ignored.
- PIN: each digit key (0-9) drives DIGITO=key and DIGITO_STB=1 for one cycle, then increments the count.
  - After the PIN_DIGITOS-th digit, go to VERIF. Non-digit keys are ignored.
  - DIGITO holds its last value between strobes.
- VERIF: count T_VERIF cycles.
  - BLOQUEO_CTRL=1 → BLOQUEADO. This takes priority over PIN_INCORRECTO.
  - PIN_INCORRECTO=1 → back to PIN with the count cleared. Latch AVISO_PIN if ADVERTENCIA=1.
  - Timer expiry with neither asserted → SEL_TIPO.
- SEL_TIPO: key A sets TIPO_TRANS=1, key B sets TIPO_TRANS=0, then go to CAPTURA. Other keys are ignored.
- CAPTURA: digit key d gives acc = acc*10 + d (32-bit). Digits beyond MAX_DIG are ignored.
  - D clears acc and the digit count.
  - C with count ≥ 1: MONTO=acc, MONTO_STB=1 for one cycle, go to ESPERA_RES.
  - C with count = 0 is ignored.
- ESPERA_RES: BALANCE_ACTUALIZADO, ENTREGAR_DINERO or FONDOS_INSUFICIENTES → FIN.
  - After T_RESP cycles with none of these: TIMEOUT pulse for one cycle, then FIN.
  - MONTO and TIPO_TRANS hold until FIN.
- FIN: TARJETA_RECIBIDA=0, AVISO_PIN=0, MONTO=0, acc cleared. Go to ESPERA_TARJETA once TARJETA_IN=0.
- BLOQUEADO: TARJETA_RECIBIDA=0. All keys and inputs are ignored. Exit only via RESET.
- Card removal (TARJETA_IN=0) in PIN, VERIF, SEL_TIPO or CAPTURA: abort to ESPERA_TARJETA the next cycle. TARJETA_RECIBIDA=0, no strobe issued, all counters cleared.
  - In ESPERA_RES, removal is ignored until a result arrives or timeout, so a dispense is never orphaned.
- Simultaneous inputs:
  - A key event in the same cycle as abort or state exit is dropped.
  - At most one strobe is asserted in any cycle.
  - DIGITO_STB and MONTO_STB are never high together.

Test Plan:
- Card in, keys 1,2,3,4 → four DIGITO_STB pulses carrying 1,2,3,4. TARJETA_RECIBIDA=1. VERIF lasts 4 cycles, then SEL_TIPO.
- PIN_INCORRECTO with ADVERTENCIA during VERIF → return to PIN and AVISO_PIN=1. Next PIN plus BLOQUEO_CTRL → BLOQUEADO: TARJETA_RECIBIDA=0 and keys give no strobes until RESET.
- Key B, then 5,0,0,C → TIPO_TRANS=0, MONTO=500 (0x1F4), one MONTO_STB. ENTREGAR_DINERO → FIN. Card out → ESPERA_TARJETA.
- Key A, then 9 repeated 11 times, then C → MONTO=999999999. Then 1,2,D,7,C on a new session → MONTO=7. Enter with no digits → no MONTO_STB.
- Key held for 10 cycles → exactly one DIGITO_STB.
- Card removed mid-PIN → TARJETA_RECIBIDA=0 next cycle, no further strobes.
- No result for 64 cycles after MONTO_STB → one TIMEOUT pulse, then FIN.
- RESET asserted in CAPTURA → all outputs 0 immediately.
